// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirect and flush pulse.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int unsigned     PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     STEP         = 1,
  parameter int unsigned     FLUSH_CYCLES = 1,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            PChold,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  input  logic            Call,
  input  logic            Ret,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PCPlus,
  output logic            Flush,
  output logic            RasOverflow,
  output logic            RasUnderflow
);

  localparam int CNT_W = 4;

  typedef enum logic {IDLE, FLUSH} state_e;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [PC_W-1:0]  pop_addr;
  logic             ret_hit;
  logic             redirect;
  state_e           st_q;
  logic [CNT_W-1:0] fcnt_q;

  assign PC     = pc_q;
  assign PCPlus = pc_q + PC_W'(STEP);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W:0]   cnt_q;
  logic             ras_full;
  logic             do_push;

  assign ras_full = cnt_q == (PTR_W+1)'(RAS_DEPTH);
  assign ret_hit  = Ret && (cnt_q != '0);
  assign pop_addr = ras_q[top_q];
  // A call that loses to a branch never happens, so it pushes nothing
  assign do_push  = Call && !ret_hit && !BranchTaken;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      top_q        <= '0;
      cnt_q        <= '0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
    end else if (ret_hit) begin
      top_q <= top_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end else begin
      if (Ret)
        RasUnderflow <= 1'b1;
      if (do_push) begin
        top_q <= top_q + 1'b1;
        if (ras_full)
          RasOverflow <= 1'b1;
        else
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst && do_push)
      ras_q[top_q + 1'b1] <= PCPlus;
  end
`else
  logic unused_ras;

  assign unused_ras   = Ret | (RAS_DEPTH < 2);
  assign ret_hit      = 1'b0;
  assign pop_addr     = '0;
  assign RasOverflow  = 1'b0;
  assign RasUnderflow = 1'b0;
`endif

  assign redirect = ret_hit | BranchTaken | Call | Jump;

  always_comb begin
    pc_d = PCPlus;
    priority case (1'b1)
      ret_hit:      pc_d = pop_addr;
      BranchTaken:  pc_d = BranchTarget;
      Call | Jump:  pc_d = JumpTarget;
      PChold:       pc_d = pc_q;
      default:      pc_d = PCPlus;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  // Any redirect restarts the window; hold does not freeze it
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      st_q   <= IDLE;
      fcnt_q <= '0;
      Flush  <= 1'b0;
    end else if (redirect) begin
      st_q   <= FLUSH;
      fcnt_q <= CNT_W'(FLUSH_CYCLES - 1);
      Flush  <= 1'b1;
    end else begin
      unique case (st_q)
        FLUSH: begin
          if (fcnt_q == '0) begin
            st_q  <= IDLE;
            Flush <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        default: begin
          st_q  <= IDLE;
          Flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: cycle model plus literal checkpoints.
// Covers the return-address stack when PC_RAS_EN is defined.
module tb_pc_unit;

  localparam int unsigned PC_W = 16;
  localparam logic [15:0] RPC  = 16'h0100;
  localparam int unsigned STEP = 1;
  localparam int unsigned FC   = 2;
  localparam int unsigned DEP  = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        PChold, BranchTaken, Jump, Call, Ret;
  logic [15:0] BranchTarget, JumpTarget;
  logic [15:0] PC, PCPlus;
  logic        Flush, RasOverflow, RasUnderflow;

  logic       z = 1'b0;
  logic [7:0] z8 = 8'h00;
  logic [7:0] w_PC, w_PCPlus;
  logic       w_Flush, w_Ovf, w_Unf;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_unit #(
    .PC_W(PC_W), .RESET_PC(RPC), .STEP(STEP),
    .FLUSH_CYCLES(FC), .RAS_DEPTH(DEP)
  ) u_dut (
    .Clk(Clk), .Rst(Rst), .PChold(PChold),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .Call(Call), .Ret(Ret),
    .PC(PC), .PCPlus(PCPlus), .Flush(Flush),
    .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
  );

  pc_unit #(
    .PC_W(8), .RESET_PC(8'hFD), .STEP(1),
    .FLUSH_CYCLES(1), .RAS_DEPTH(2)
  ) u_w8 (
    .Clk(Clk), .Rst(Rst), .PChold(z),
    .BranchTaken(z), .BranchTarget(z8),
    .Jump(z), .JumpTarget(z8),
    .Call(z), .Ret(z),
    .PC(w_PC), .PCPlus(w_PCPlus), .Flush(w_Flush),
    .RasOverflow(w_Ovf), .RasUnderflow(w_Unf)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  // Behavioural model: flush as "cycles left", stack as a queue
  logic [15:0] m_pc;
  int          m_fl;
  logic [15:0] m_ras [$];
  bit          m_ovf, m_unf, m_valid;
  bit          m_ret_ok, m_redir;
  logic [7:0]  w_pc;

  initial m_valid = 1'b0;

  always @(posedge Clk) begin
    if (!Rst) begin
      m_pc  = RPC;
      m_fl  = 0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      w_pc  = 8'hFD;
    end else begin
      w_pc     = w_pc + 8'd1;
      m_ret_ok = 1'b0;
`ifdef PC_RAS_EN
      m_ret_ok = Ret && (m_ras.size() > 0);
`endif
      m_redir = m_ret_ok || BranchTaken || Call || Jump;
      if (m_ret_ok) begin
        m_pc = m_ras.pop_back();
      end else begin
`ifdef PC_RAS_EN
        if (Ret) m_unf = 1'b1;
        if (Call && !BranchTaken) begin
          m_ras.push_back(m_pc + 16'(STEP));
          if (m_ras.size() > DEP) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end
`endif
        if (BranchTaken)      m_pc = BranchTarget;
        else if (Call | Jump) m_pc = JumpTarget;
        else if (!PChold)     m_pc = m_pc + 16'(STEP);
      end
      if (m_redir)       m_fl = FC;
      else if (m_fl > 0) m_fl = m_fl - 1;
    end
    m_valid = 1'b1;
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("pc", PC, m_pc);
      chk("pcplus", PCPlus, m_pc + 16'(STEP));
      chk("flush", Flush, m_fl > 0);
      chk("ovf", RasOverflow, m_ovf);
      chk("unf", RasUnderflow, m_unf);
      chk("w8_pc", w_PC, w_pc);
      chk("w8_flush", w_Flush, 1'b0);
      chk("w8_flags", {w_Ovf, w_Unf}, 2'b00);
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clr();
    PChold       = 1'b0;
    BranchTaken  = 1'b0;
    Jump         = 1'b0;
    Call         = 1'b0;
    Ret          = 1'b0;
    BranchTarget = '0;
    JumpTarget   = '0;
  endtask

  logic [15:0] ret_exp [5];

  initial begin
    clr();
    Rst = 1'b0;
    tick();
    tick();
    chk("L_rst_pc", PC, 16'h0100);
    chk("L_rst_flush", Flush, 1'b0);
    Rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("L_inc_pc", PC, 32'h0100 + i);
      chk("L_inc_flush", Flush, 1'b0);
    end
    chk("L_wrap_pc", w_PC, 8'h00);
    chk("L_wrap_plus", w_PCPlus, 8'h01);

    Jump = 1'b1; JumpTarget = 16'h0010;
    tick();
    clr(); PChold = 1'b1;
    tick();
    tick();
    chk("L_hold_pc", PC, 16'h0010);
    chk("L_hold_flush", Flush, 1'b0);
    Jump = 1'b1; JumpTarget = 16'h0040;
    tick();
    chk("L_hj_pc", PC, 16'h0040);
    chk("L_hj_flush", Flush, 1'b1);
    Jump = 1'b0;
    tick();
    chk("L_hj_flush2", Flush, 1'b1);
    tick();
    chk("L_hj_flush3", Flush, 1'b0);

    clr();
    BranchTaken = 1'b1; BranchTarget = 16'h0200;
    Jump = 1'b1; JumpTarget = 16'h0300;
    tick();
    chk("L_prio_pc", PC, 16'h0200);
    clr();
    BranchTaken = 1'b1; BranchTarget = 16'h0220;
    tick();
    chk("L_rst2_pc", PC, 16'h0220);
    clr();
    tick();
    chk("L_rst2_f3", Flush, 1'b1);
    tick();
    chk("L_rst2_f4", Flush, 1'b0);
    chk("L_rst2_pc4", PC, 16'h0222);

    Jump = 1'b1; JumpTarget = 16'h000A;
    tick();
    clr();
    Call = 1'b1; JumpTarget = 16'h0050;
    tick();
    chk("L_call_pc", PC, 16'h0050);
    chk("L_call_flush", Flush, 1'b1);
    clr(); Ret = 1'b1;
    tick();
`ifdef PC_RAS_EN
    chk("L_ret_pc", PC, 16'h000B);
`else
    chk("L_ret_pc", PC, 16'h0051);
`endif
    clr();
    for (int i = 0; i < 5; i++) begin
      Call = 1'b1; JumpTarget = 16'h0100 + 16'(i * 16);
      tick();
    end
    chk("L_nest_pc", PC, 16'h0140);
`ifdef PC_RAS_EN
    chk("L_ovf", RasOverflow, 1'b1);
    ret_exp = '{16'h0131, 16'h0121, 16'h0111, 16'h0101, 16'h0102};
`else
    chk("L_ovf", RasOverflow, 1'b0);
    ret_exp = '{16'h0141, 16'h0142, 16'h0143, 16'h0144, 16'h0145};
`endif
    clr(); Ret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("L_pop_pc", PC, ret_exp[i]);
    end
`ifdef PC_RAS_EN
    chk("L_unf", RasUnderflow, 1'b1);
`else
    chk("L_unf", RasUnderflow, 1'b0);
`endif

    clr();
    Call = 1'b1; JumpTarget = 16'h0600;
    tick();
    JumpTarget = 16'h0700;
    tick();
    clr(); Jump = 1'b1; JumpTarget = 16'h0800;
    tick();
    chk("L_mid_flush", Flush, 1'b1);
    clr(); Rst = 1'b0; Jump = 1'b1; JumpTarget = 16'h0900;
    tick();
    chk("L_mr_pc", PC, 16'h0100);
    chk("L_mr_flush", Flush, 1'b0);
    chk("L_mr_flags", {RasOverflow, RasUnderflow}, 2'b00);
    clr(); Rst = 1'b1; Ret = 1'b1;
    tick();
    chk("L_mr_ret_pc", PC, 16'h0101);
    chk("L_mr_ret_flush", Flush, 1'b0);
`ifdef PC_RAS_EN
    chk("L_mr_unf", RasUnderflow, 1'b1);
`else
    chk("L_mr_unf", RasUnderflow, 1'b0);
`endif
    clr();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
